golden_nonce_queue: RTL and testbench

// - Buffers golden nonces reported by the hashing core and feeds them one 32-bit word at a time to serial_transmit (send/word/busy).
// - Sits between the miner's nonce-found strobe and the UART transmit path.
// - Nonces that arrive while the UART is busy are queued, not lost.
// - Clocked at the comm clock.

---
 rtl/golden_nonce_queue.sv | 192 +++++++++++++++++++
 tb/tb_golden_nonce_queue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/golden_nonce_queue.sv
// Golden nonce queue: buffers nonces from the hashing core and hands them one 32-bit word at a
// time to serial_transmit using a send/busy handshake.
// Optional feature: define NONCE_DEDUP_EN to discard a nonce equal to the last accepted one.
module golden_nonce_queue #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     nonce_valid,
  input  logic [31:0]              nonce,
  input  logic                     tx_busy,
  output logic                     tx_send,
  output logic [31:0]              tx_word,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TmrW = $clog2(BUSY_TIMEOUT) + 1;

  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWaitHi,
    StWaitLo
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     mem_d [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic            tx_send_q, tx_send_d;
  logic [31:0]     tx_word_q, tx_word_d;
  logic            overflow_q, overflow_d;

  logic is_dup;
  logic full;
  logic push;
  logic drop;
  logic pop;

`ifdef NONCE_DEDUP_EN
  logic [31:0] last_nonce_q, last_nonce_d;
  logic        last_valid_q, last_valid_d;

  // Duplicate of the last accepted nonce is ignored before full/overflow is considered.
  always_comb begin
    is_dup = last_valid_q && (nonce == last_nonce_q);
  end

  // Only nonces that actually enter the queue update the dedup reference.
  always_comb begin
    last_nonce_d = last_nonce_q;
    last_valid_d = last_valid_q;
    if (push) begin
      last_nonce_d = nonce;
      last_valid_d = 1'b1;
    end
  end

  // Dedup reference register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_nonce_q <= '0;
      last_valid_q <= 1'b0;
    end else begin
      last_nonce_q <= last_nonce_d;
      last_valid_q <= last_valid_d;
    end
  end
`else
  // Without dedup every strobe is a candidate for the queue.
  always_comb begin
    is_dup = 1'b0;
  end
`endif

  // Push/drop decision; full is judged on the registered count, ignoring a same-cycle pop.
  always_comb begin
    full = (count_q == CntFull);
    push = nonce_valid && !is_dup && !full;
    drop = nonce_valid && !is_dup && full;
  end

  // Transmit FSM: pop in IDLE, pulse send, wait for busy to rise (or time out), wait for it to fall.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    tx_send_d = 1'b0;
    tx_word_d = tx_word_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((count_q != '0) && !tx_busy) begin
          pop       = 1'b1;
          tx_send_d = 1'b1;
          tx_word_d = mem_q[rd_ptr_q];
          state_d   = StSend;
        end
      end
      StSend: begin
        timer_d = '0;
        state_d = StWaitHi;
      end
      StWaitHi: begin
        if (tx_busy) begin
          state_d = StWaitLo;
        end else if (timer_q == TmrLast) begin
          // UART never acknowledged; the word is treated as sent.
          state_d = StIdle;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      StWaitLo: begin
        if (!tx_busy) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FIFO storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = nonce;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Sticky overflow flag.
  always_comb begin
    overflow_d = overflow_q | drop;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      tx_send_q  <= 1'b0;
      tx_word_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      tx_send_q  <= tx_send_d;
      tx_word_q  <= tx_word_d;
      overflow_q <= overflow_d;
    end
  end

  // Queue storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign tx_send    = tx_send_q;
  assign tx_word    = tx_word_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_golden_nonce_queue.sv
// Scoreboard bench for golden_nonce_queue: stimulus queues expected words, a monitor checks
// every tx_send pulse against them; a small UART model drives tx_busy.
module tb_golden_nonce_queue;

  localparam int unsigned Depth   = 8;
  localparam int unsigned Timeout = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        nonce_valid;
  logic [31:0] nonce;
  logic        tx_busy;
  logic        tx_send;
  logic [31:0] tx_word;
  logic [3:0]  fifo_count;
  logic        overflow;

  logic        hold_busy;
  int          busy_len;
  int          busy_cnt = 0;

  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;
  logic        prev_busy;
  int          errors = 0;
  int          checks = 0;

  golden_nonce_queue #(
    .DEPTH       (Depth),
    .BUSY_TIMEOUT(Timeout)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .nonce_valid(nonce_valid),
    .nonce      (nonce),
    .tx_busy    (tx_busy),
    .tx_send    (tx_send),
    .tx_word    (tx_word),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // UART model: busy for busy_len cycles after each send, or held high by the stimulus.
  always @(posedge clk) begin
    if (tx_send) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = hold_busy || (busy_cnt != 0);

  // Monitor: every send must match the next expected word and follow a cycle with busy low.
  initial begin
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && tx_send) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL send_unexpected: got word %h, required no send", tx_word);
        end else begin
          mon_exp = exp_q.pop_front();
          if (tx_word !== mon_exp) begin
            errors++;
            $display("FAIL send_word: got %h, required %h", tx_word, mon_exp);
          end
        end
        checks++;
        if (prev_busy) begin
          errors++;
          $display("FAIL send_while_busy: got busy=1 before send, required 0");
        end
      end
      prev_busy = tx_busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] v);
    nonce       = v;
    nonce_valid = 1'b1;
    tick();
    nonce_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d words pending after %0d cycles, required 0", name, exp_q.size(), n);
    end
    repeat (60) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n       = 1'b0;
    nonce_valid = 1'b0;
    nonce       = '0;
    hold_busy   = 1'b0;
    busy_len    = 3;
    tick();
    tick();
    chk("reset_count", 32'(fifo_count), 32'd0);
    chk("reset_send", 32'(tx_send), 32'd0);
    chk("reset_word", tx_word, 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single nonce: count=1 at cycle 1, send at cycle 2.
    exp_q.push_back(32'hDEADBEEF);
    push_word(32'hDEADBEEF);
    chk("single_count_c1", 32'(fifo_count), 32'd1);
    tick();
    chk("single_send_c2", 32'(tx_send), 32'd1);
    chk("single_word_c2", tx_word, 32'hDEADBEEF);
    chk("single_count_c2", 32'(fifo_count), 32'd0);
    tick();
    chk("single_send_c3", 32'(tx_send), 32'd0);
    drain("single_drain", 50);

    // Burst with a slow UART.
    busy_len = 40;
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(32'(i));
      push_word(32'(i));
    end
    drain("burst_drain", 400);

    // Overflow: nine nonces while the UART is held busy.
    busy_len  = 3;
    hold_busy = 1'b1;
    tick();
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) exp_q.push_back(32'(i));
      push_word(32'(i));
    end
    chk("ovf_count", 32'(fifo_count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    hold_busy = 1'b0;
    drain("ovf_drain", 300);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Push at full coinciding with a pop: the new nonce is dropped.
    do_reset();
    chk("reset_clears_ovf", 32'(overflow), 32'd0);
    hold_busy = 1'b1;
    tick();
    for (int i = 10; i < 18; i++) begin
      exp_q.push_back(32'(i));
      push_word(32'(i));
    end
    chk("full_count", 32'(fifo_count), 32'd8);
    chk("full_no_ovf", 32'(overflow), 32'd0);
    hold_busy = 1'b0;
    push_word(32'd99);
    chk("pushpop_full_count", 32'(fifo_count), 32'd7);
    chk("pushpop_full_ovf", 32'(overflow), 32'd1);
    chk("pushpop_full_send", 32'(tx_send), 32'd1);
    drain("pushpop_drain", 300);

    // Reset while waiting for busy to fall with three entries queued.
    hold_busy = 1'b1;
    busy_len  = 40;
    tick();
    for (int i = 20; i < 24; i++) push_word(32'(i));
    exp_q.push_back(32'd20);
    hold_busy = 1'b0;
    tick();
    chk("midxfer_send", 32'(tx_send), 32'd1);
    chk("midxfer_count", 32'(fifo_count), 32'd3);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midxfer_rst_count", 32'(fifo_count), 32'd0);
    chk("midxfer_rst_send", 32'(tx_send), 32'd0);
    chk("midxfer_rst_word", tx_word, 32'd0);
    chk("midxfer_rst_ovf", 32'(overflow), 32'd0);
    n = 0;
    while (tx_busy && n < 100) begin
      tick();
      n++;
    end
    chk("midxfer_busy_falls", 32'(tx_busy), 32'd0);
    busy_len = 3;
    exp_q.push_back(32'd30);
    push_word(32'd30);
    chk("post_rst_count_c1", 32'(fifo_count), 32'd1);
    tick();
    chk("post_rst_send_c2", 32'(tx_send), 32'd1);
    chk("post_rst_word_c2", tx_word, 32'd30);
    drain("post_rst_drain", 50);

    // Timeout: busy never rises, so sends are BUSY_TIMEOUT+2 cycles apart.
    busy_len = 0;
    exp_q.push_back(32'd40);
    exp_q.push_back(32'd41);
    push_word(32'd40);
    push_word(32'd41);
    chk("tmo_send_first", 32'(tx_send), 32'd1);
    chk("tmo_word_first", tx_word, 32'd40);
    chk("tmo_count_pushpop", 32'(fifo_count), 32'd1);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (tx_send) n++;
    end
    chk("tmo_quiet_cycles", 32'(n), 32'd0);
    tick();
    chk("tmo_send_second", 32'(tx_send), 32'd1);
    chk("tmo_word_second", tx_word, 32'd41);
    drain("tmo_drain", 50);

    // Duplicate nonces.
    busy_len = 3;
    exp_q.push_back(32'd5);
`ifndef NONCE_DEDUP_EN
    exp_q.push_back(32'd5);
`endif
    exp_q.push_back(32'd6);
    push_word(32'd5);
    push_word(32'd5);
    push_word(32'd6);
    drain("dedup_drain", 200);
    chk("final_count", 32'(fifo_count), 32'd0);
    chk("final_ovf", 32'(overflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
